// File: rtl/eco32_core_lsu_dcu_pwb.sv
// rtl/eco32_core_lsu_dcu_pwb.sv - page-write-buffer flush sequencer for the LSU data cache
//
// Walks every {way,page} of one thread, reads the page-written flag, and for
// each flagged page issues a writeback request followed by a flag clear.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   f_req, f_tid           flush request and thread id (taken only while f_rdy)
//   f_rdy, f_done          idle indicator, one-cycle scan-complete pulse
//   r_tid, r_wid, r_page   flag read address; r_pwf returns its flag one cycle later
//   wb_stb, wb_tid, wb_wid, wb_page, wb_ack   writeback request handshake
//   w_clr, w_wen, w_tid, w_wid, w_page        flag-clear command to the tracker
module eco32_core_lsu_dcu_pwb #(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_req,
    input  logic                       f_tid,
    output logic                       f_rdy,
    output logic                       f_done,
    output logic                       r_tid,
    output logic                       r_wid,
    output logic [PAGE_ADDR_WIDTH-1:0] r_page,
    input  logic                       r_pwf,
    output logic                       wb_stb,
    output logic                       wb_tid,
    output logic                       wb_wid,
    output logic [PAGE_ADDR_WIDTH-1:0] wb_page,
    input  logic                       wb_ack,
    output logic                       w_clr,
    output logic                       w_wen,
    output logic                       w_tid,
    output logic                       w_wid,
    output logic [PAGE_ADDR_WIDTH-1:0] w_page
);

    localparam int IW = PAGE_ADDR_WIDTH + 1;
    localparam logic [IW-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_REQ,
        S_CLR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          tid_q, tid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          f_rdy_q, f_rdy_d;
    logic          f_done_q, f_done_d;
    logic          r_tid_q, r_tid_d;
    logic [IW-1:0] r_idx_q, r_idx_d;
    logic          wb_stb_q, wb_stb_d;
    logic          wb_tid_q, wb_tid_d;
    logic [IW-1:0] wb_idx_q, wb_idx_d;
    logic          w_clr_q, w_clr_d;
    logic          w_wen_q, w_wen_d;
    logic          w_tid_q, w_tid_d;
    logic [IW-1:0] w_idx_q, w_idx_d;

    always_comb begin
        state_d  = state_q;
        tid_d    = tid_q;
        idx_d    = idx_q;
        r_tid_d  = r_tid_q;
        r_idx_d  = r_idx_q;
        wb_tid_d = wb_tid_q;
        wb_idx_d = wb_idx_q;
        w_tid_d  = w_tid_q;
        w_idx_d  = w_idx_q;

        case (state_q)
            S_IDLE: begin
                if (f_req) begin
                    tid_d   = f_tid;
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // r_pwf belongs to the address driven during the preceding READ
                if (r_pwf) begin
                    state_d = S_REQ;
                end else if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_REQ: begin
                if (wb_ack) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                // the last index terminates the scan rather than wrapping to 0
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so each register shows
        // the value belonging to the state it is in.
        f_rdy_d  = (state_d == S_IDLE);
        f_done_d = (state_d == S_DONE);
        wb_stb_d = (state_d == S_REQ);
        w_clr_d  = (state_d == S_CLR);
        w_wen_d  = (state_d == S_CLR);

        if (state_d == S_READ) begin
            r_tid_d = tid_d;
            r_idx_d = idx_d;
        end
        if (state_q == S_CHECK && state_d == S_REQ) begin
            wb_tid_d = tid_q;
            wb_idx_d = idx_q;
        end
        if (state_q == S_REQ && state_d == S_CLR) begin
            w_tid_d = wb_tid_q;
            w_idx_d = wb_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tid_q    <= 1'b0;
            idx_q    <= '0;
            f_rdy_q  <= 1'b1;
            f_done_q <= 1'b0;
            r_tid_q  <= 1'b0;
            r_idx_q  <= '0;
            wb_stb_q <= 1'b0;
            wb_tid_q <= 1'b0;
            wb_idx_q <= '0;
            w_clr_q  <= 1'b0;
            w_wen_q  <= 1'b0;
            w_tid_q  <= 1'b0;
            w_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            tid_q    <= tid_d;
            idx_q    <= idx_d;
            f_rdy_q  <= f_rdy_d;
            f_done_q <= f_done_d;
            r_tid_q  <= r_tid_d;
            r_idx_q  <= r_idx_d;
            wb_stb_q <= wb_stb_d;
            wb_tid_q <= wb_tid_d;
            wb_idx_q <= wb_idx_d;
            w_clr_q  <= w_clr_d;
            w_wen_q  <= w_wen_d;
            w_tid_q  <= w_tid_d;
            w_idx_q  <= w_idx_d;
        end
    end

    assign f_rdy   = f_rdy_q;
    assign f_done  = f_done_q;
    assign r_tid   = r_tid_q;
    assign r_wid   = r_idx_q[IW-1];
    assign r_page  = r_idx_q[PAGE_ADDR_WIDTH-1:0];
    assign wb_stb  = wb_stb_q;
    assign wb_tid  = wb_tid_q;
    assign wb_wid  = wb_idx_q[IW-1];
    assign wb_page = wb_idx_q[PAGE_ADDR_WIDTH-1:0];
    assign w_clr   = w_clr_q;
    assign w_wen   = w_wen_q;
    assign w_tid   = w_tid_q;
    assign w_wid   = w_idx_q[IW-1];
    assign w_page  = w_idx_q[PAGE_ADDR_WIDTH-1:0];

endmodule

// File: doc/eco32_core_lsu_dcu_pwb.md
ECO32_CORE_LSU_DCU_PWB -- requirements
Module: eco32_core_lsu_dcu_pwb

Interface
REQ-001 SHALL have parameter PAGE_ADDR_WIDTH, default 5: page index width; pages per way = 2^PAGE_ADDR_WIDTH (N).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port f_req  in  1  flush request; sampled only while f_rdy=1.
REQ-005 SHALL have port f_tid  in  1  thread to flush; captured with f_req.
REQ-006 SHALL have port f_rdy  out  1  high only in IDLE.
REQ-007 SHALL have port f_done  out  1  one-cycle pulse at scan completion.
REQ-008 SHALL have ports r_tid, r_wid (out, 1 bit each) and r_page (out, PAGE_ADDR_WIDTH): page-written flag read address.
REQ-009 SHALL have port r_pwf  in  1  flag for the address presented in the previous cycle.
REQ-010 SHALL have ports wb_stb (out, 1), wb_tid (out, 1), wb_wid (out, 1), wb_page (out, PAGE_ADDR_WIDTH): writeback request.
REQ-011 SHALL have port wb_ack  in  1  writeback accepted; ignored while wb_stb=0.
REQ-012 SHALL have ports w_clr, w_wen, w_tid, w_wid (out, 1 bit each) and w_page (out, PAGE_ADDR_WIDTH): flag-clear command to the page-write-flag tracker.

Function
REQ-013 SHALL implement FSM states IDLE, READ, CHECK, REQ, CLR, DONE; all outputs registered.
REQ-014 SHALL, in IDLE with f_req=1, capture f_tid, zero scan index idx (PAGE_ADDR_WIDTH+1 bits, {wid,page}), and enter READ.
REQ-015 SHALL in READ drive r_tid=captured tid, {r_wid,r_page}=idx, then enter CHECK.
REQ-016 SHALL in CHECK sample r_pwf: 1 -> REQ; 0 and idx not last -> idx+1, READ; 0 and idx last -> DONE.
REQ-017 SHALL scan order way 0 pages 0..N-1, then way 1 pages 0..N-1; last idx = 2N-1; idx never wraps to 0 within a scan.
REQ-018 SHALL in REQ hold wb_stb=1 with wb_tid/wb_wid/wb_page stable until the cycle wb_ack=1, then deassert wb_stb next cycle and enter CLR.
REQ-019 SHALL in CLR assert w_clr=1, w_wen=1, w_tid/w_wid/w_page = the acknowledged entry for exactly one cycle, then go to READ with idx+1, or to DONE if idx was last.
REQ-020 SHALL hold w_clr=0 and w_wen=0 in every state other than CLR.
REQ-021 SHALL in DONE pulse f_done=1 for one cycle, then return to IDLE.
REQ-022 SHALL ignore f_req while f_rdy=0; no queuing.
REQ-023 SHALL give a clean-page cost of 2 cycles (READ+CHECK) and a dirty-page cost of READ+CHECK+(REQ cycles until ack)+CLR.
REQ-024 SHALL, for an all-clean scan, assert f_done 2*2N+1 cycles after the f_req acceptance edge (129 for PAGE_ADDR_WIDTH=5).
REQ-025 SHALL keep the flushed thread's stores stalled as a caller obligation; the block does not re-check a flag after CHECK.

Reset
REQ-026 SHALL on rst=1 at a clock edge enter IDLE; outputs f_rdy=1, f_done=0, wb_stb=0, w_clr=0, w_wen=0; all address/tid/wid outputs and idx = 0.
REQ-027 SHALL on rst mid-scan (including during REQ) drop wb_stb on the next cycle, issue no w_clr, and not pulse f_done.

Verification
REQ-028 SHALL cover: reset, all flags clean, f_req with f_tid=0 -> 64 reads with r_tid=0, no wb_stb, f_done at cycle 129, f_rdy=1 afterwards.
REQ-029 SHALL cover: tid1 way1 page3 dirty, wb_ack held off 5 cycles -> wb_stb high 5 cycles with wb_tid=1, wb_wid=1, wb_page=3; next cycle w_clr=w_wen=1 with the same fields for 1 cycle.
REQ-030 SHALL cover: way0 page0 and way1 page31 dirty -> exactly two writebacks, in that order; scan ends after idx 63 with a single f_done.
REQ-031 SHALL cover: f_req pulsed during scan, and wb_ack pulsed while wb_stb=0 -> no effect on state, idx, or outputs.
REQ-032 SHALL cover: rst asserted during REQ -> wb_stb=0 next cycle, no w_clr, f_rdy=1, and a subsequent f_req rescans from idx 0.
